// File: rtl/pico_mm_stream_fifo_slave_if.sv
// PicoMm bus port plus TX/RX stream handshakes for the FIFO slave.
interface pico_mm_stream_fifo_slave_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic          write;
  logic [31:0]   wrdata;
  logic          read;
  logic [31:0]   rddata;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport master (
    output addr, write, wrdata, read,
    output tx_ready, rx_data, rx_valid,
    input  rddata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  addr, write, wrdata, read,
    input  tx_ready, rx_data, rx_valid,
    output rddata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/pico_mm_stream_fifo_slave.sv
// PicoMm slave bridging the CPU bus to a TX and an RX stream FIFO.
// Optional irq output enabled by PICO_MM_FIFO_IRQ_EN.
module pico_mm_stream_fifo_slave #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  pico_mm_stream_fifo_slave_if.slave bus
`ifdef PICO_MM_FIFO_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] r_tx_mem [DEPTH];
  logic [DW-1:0] r_rx_mem [DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp;
  logic [PW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic          r_tx_ovf, r_rx_udf;
  logic [31:0]   r_rddata;
  logic [31:0]   w_rd_mux;
  logic [1:0]    w_sel;
  logic          w_wr_data, w_wr_stat, w_wr_ctrl;
  logic          w_rd_data;
  logic          w_tx_full, w_tx_empty;
  logic          w_rx_full, w_rx_empty;
  logic          w_tx_push, w_tx_pop, w_tx_flush;
  logic          w_rx_push, w_rx_pop, w_rx_flush;
  logic          w_unused;

  assign w_sel     = bus.addr[1:0];
  assign w_wr_data = bus.write & (w_sel == 2'd0);
  assign w_wr_stat = bus.write & (w_sel == 2'd1);
  assign w_wr_ctrl = bus.write & (w_sel == 2'd2);
  assign w_rd_data = bus.read  & (w_sel == 2'd0);
  assign w_unused  = ^{bus.addr, bus.wrdata};

  assign w_tx_full  = r_tx_cnt == CW'(DEPTH);
  assign w_tx_empty = r_tx_cnt == '0;
  assign w_rx_full  = r_rx_cnt == CW'(DEPTH);
  assign w_rx_empty = r_rx_cnt == '0;

  assign w_tx_flush = w_wr_ctrl & bus.wrdata[0];
  assign w_rx_flush = w_wr_ctrl & bus.wrdata[1];
  assign w_tx_push  = w_wr_data & !w_tx_full;
  assign w_tx_pop   = !w_tx_empty & bus.tx_ready;
  assign w_rx_pop   = w_rd_data & !w_rx_empty;
  assign w_rx_push  = bus.rx_valid & bus.rx_ready;

  // A bus pop frees the slot, so a full RX may still accept a stream word
  assign bus.rx_ready = !w_rx_full | w_rx_pop;
  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = r_tx_mem[r_tx_rp];
  assign bus.rddata   = r_rddata;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.wrdata[DW-1:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else if (w_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push & !w_tx_pop)
        r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (w_tx_pop & !w_tx_push)
        r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push & !w_rx_pop)
        r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (w_rx_pop & !w_rx_push)
        r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      if (w_wr_data & w_tx_full)
        r_tx_ovf <= 1'b1;
      else if (w_wr_stat & bus.wrdata[18])
        r_tx_ovf <= 1'b0;
      if (w_rd_data & w_rx_empty)
        r_rx_udf <= 1'b1;
      else if (w_wr_stat & bus.wrdata[19])
        r_rx_udf <= 1'b0;
    end
  end

`ifdef PICO_MM_FIFO_IRQ_EN
  logic [10:0] r_irqcfg;
  logic        r_irq;
  logic        w_irq_nxt;

  assign w_irq_nxt =
      (r_irqcfg[8] & (8'(r_rx_cnt) >= r_irqcfg[7:0])
                   & (r_irqcfg[7:0] != 8'd0))
    | (r_irqcfg[9] & w_tx_empty)
    | (r_irqcfg[10] & (r_tx_ovf | r_rx_udf));
  assign irq = r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irqcfg <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (bus.write & (w_sel == 2'd3))
        r_irqcfg <= bus.wrdata[10:0];
      r_irq <= w_irq_nxt;
    end
  end
`endif

  always_comb begin
    w_rd_mux = '0;
    unique case (w_sel)
      2'd0: w_rd_mux = w_rx_empty ? '0
                     : 32'(r_rx_mem[r_rx_rp]);
      2'd1: w_rd_mux = {12'd0, r_rx_udf, r_tx_ovf,
                        w_rx_empty, w_tx_full,
                        8'(r_rx_cnt), 8'(r_tx_cnt)};
      2'd2: w_rd_mux = '0;
`ifdef PICO_MM_FIFO_IRQ_EN
      2'd3: w_rd_mux = 32'(r_irqcfg);
`else
      2'd3: w_rd_mux = '0;
`endif
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rddata <= '0;
    else if (bus.read)
      r_rddata <= w_rd_mux;
  end
endmodule

// File: tb/tb_pico_mm_stream_fifo_slave.sv
// Directed self-checking bench for pico_mm_stream_fifo_slave.
`timescale 1ns/1ps
module tb_pico_mm_stream_fifo_slave;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] d;
`ifdef PICO_MM_FIFO_IRQ_EN
  logic irq;
`endif

  pico_mm_stream_fifo_slave_if #(.AW(AW), .DW(DW)) bus ();

  pico_mm_stream_fifo_slave #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PICO_MM_FIFO_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(logic [AW-1:0] a, logic [31:0] v);
    bus.addr = a;
    bus.wrdata = v;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic bus_rd(logic [AW-1:0] a, output logic [31:0] v);
    bus.addr = a;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    v = bus.rddata;
  endtask

  task automatic rx_push(logic [31:0] v);
    bus.rx_data = v;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    bus.addr = '0;
    bus.write = 1'b0;
    bus.wrdata = '0;
    bus.read = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    tick();
    tick();
    chk("rst_rddata", bus.rddata, 32'h0);
    chk("rst_txvalid", bus.tx_valid, 1'b0);
    chk("rst_rxready", bus.rx_ready, 1'b1);
    rst = 1'b0;
    tick();
    bus_rd(4'd1, d);
    chk("rst_status", d, 32'h0002_0000);

    // TX stream order
    bus_wr(4'd0, 32'hA5);
    bus_wr(4'd0, 32'h5A);
    chk("tx_valid1", bus.tx_valid, 1'b1);
    chk("tx_head_a5", bus.tx_data, 32'hA5);
    bus.tx_ready = 1'b1;
    tick();
    chk("tx_head_5a", bus.tx_data, 32'h5A);
    chk("tx_valid2", bus.tx_valid, 1'b1);
    tick();
    chk("tx_valid_fall", bus.tx_valid, 1'b0);
    bus.tx_ready = 1'b0;

    // RX stream into bus reads
    rx_push(32'h11);
    rx_push(32'h22);
    rx_push(32'h33);
    bus_rd(4'd1, d);
    chk("rx_status3", d, 32'h0000_0300);
    bus_rd(4'd0, d);
    chk("rx_rd0", d, 32'h11);
    bus_rd(4'd0, d);
    chk("rx_rd1", d, 32'h22);
    tick();
    chk("rddata_hold", bus.rddata, 32'h22);
    bus_rd(4'd4, d);
    chk("rx_rd2_alias", d, 32'h33);
    bus_rd(4'd0, d);
    chk("rx_rd_empty", d, 32'h0);
    bus_rd(4'd1, d);
    chk("rx_udf_set", d, 32'h000A_0000);
    bus_wr(4'd1, 32'h0008_0000);
    bus_rd(4'd1, d);
    chk("rx_udf_clr", d, 32'h0002_0000);

    // TX overflow
    for (int i = 0; i <= DEPTH; i++) bus_wr(4'd0, 32'(i + 1));
    bus_rd(4'd1, d);
    chk("tx_ovf_set", d, 32'h0007_0010);
    bus_wr(4'd1, 32'h0004_0000);
    bus_rd(4'd1, d);
    chk("tx_ovf_clr", d, 32'h0003_0010);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("tx_drain", bus.tx_data, 32'(i + 1));
      tick();
    end
    bus.tx_ready = 1'b0;
    chk("tx_drained", bus.tx_valid, 1'b0);

    // RX full with simultaneous bus pop and stream push
    for (int i = 0; i < DEPTH; i++) rx_push(32'h100 + 32'(i));
    chk("rx_full_rdy", bus.rx_ready, 1'b0);
    bus.addr = 4'd0;
    bus.read = 1'b1;
    bus.rx_data = 32'h200;
    bus.rx_valid = 1'b1;
    #1;
    chk("rx_full_pop_rdy", bus.rx_ready, 1'b1);
    tick();
    bus.read = 1'b0;
    bus.rx_valid = 1'b0;
    chk("rx_full_rd", bus.rddata, 32'h100);
    bus_rd(4'd1, d);
    chk("rx_full_cnt", d, 32'h0000_1000);
    for (int i = 1; i < DEPTH; i++) begin
      bus_rd(4'd0, d);
      chk("rx_order", d, 32'h100 + 32'(i));
    end
    bus_rd(4'd0, d);
    chk("rx_last", d, 32'h200);
    bus_rd(4'd1, d);
    chk("rx_empty_again", d, 32'h0002_0000);

    // flush both FIFOs
    bus_wr(4'd0, 32'h7);
    bus_wr(4'd0, 32'h8);
    rx_push(32'h9);
    rx_push(32'hA);
    bus_rd(4'd1, d);
    chk("pre_flush", d, 32'h0000_0202);
    bus_wr(4'd2, 32'h3);
    chk("flush_txvalid", bus.tx_valid, 1'b0);
    bus_rd(4'd1, d);
    chk("post_flush", d, 32'h0002_0000);
    bus_rd(4'd2, d);
    chk("ctrl_rd", d, 32'h0);

`ifdef PICO_MM_FIFO_IRQ_EN
    bus_wr(4'd3, 32'h102);
    rx_push(32'h1);
    rx_push(32'h2);
    chk("irq_lag", irq, 1'b0);
    tick();
    chk("irq_set", irq, 1'b1);
    bus_rd(4'd0, d);
    tick();
    chk("irq_clr", irq, 1'b0);
    bus_wr(4'd3, 32'h0);
    bus_wr(4'd2, 32'h3);
`else
    bus_wr(4'd3, 32'h7FF);
    bus_rd(4'd3, d);
    chk("irqcfg_absent", d, 32'h0);
`endif

    // reset mid-stream
    bus_wr(4'd0, 32'hDEAD);
    rx_push(32'h55);
    bus_rd(4'd0, d);
    chk("pre_rst_rd", d, 32'h55);
    rx_push(32'h66);
    chk("pre_rst_txv", bus.tx_valid, 1'b1);
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rddata", bus.rddata, 32'h0);
    chk("mid_rst_txvalid", bus.tx_valid, 1'b0);
    chk("mid_rst_rxready", bus.rx_ready, 1'b1);
    tick();
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    tick();
    bus_rd(4'd1, d);
    chk("post_rst_status", d, 32'h0002_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
